// File: rtl/byte_parity_fifo.sv
// Ready/valid FIFO storing one XNOR parity bit per data byte; parity is
// recomputed at the head and mismatches are flagged per byte and sticky.
module byte_parity_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BYTES = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       enq_valid,
    output logic                                       enq_ready,
    input  logic [8*BYTES-1:0]                         enq_data,
    input  logic                                       inj_err,
    input  logic [((BYTES > 1) ? $clog2(BYTES) : 1)-1:0] inj_byte,
    output logic                                       deq_valid,
    input  logic                                       deq_ready,
    output logic [8*BYTES-1:0]                         deq_data,
    output logic [BYTES-1:0]                           deq_par_err,
    output logic                                       err_sticky,
    input  logic                                       clr_err,
    output logic [$clog2(DEPTH):0]                     count
);

    localparam int unsigned DW  = 8 * BYTES;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned IBW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef struct packed {
        logic [BYTES-1:0] par;
        logic [DW-1:0]    data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          err_q, err_d;

    logic          full, empty;
    logic          enq_fire, deq_fire;
    entry_t        head;
    entry_t        wr_entry;
    logic [BYTES-1:0] inj_mask;
    logic [BYTES-1:0] par_err_c;

    // Per-byte XNOR reduction: 1 when the byte holds an even number of ones.
    function automatic logic [BYTES-1:0] byte_xnor(input logic [DW-1:0] w);
        logic [BYTES-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            r[i] = ~^w[8*i +: 8];
        end
        return r;
    endfunction

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign enq_fire = enq_valid && !full;
    assign deq_fire = deq_ready && !empty;

    always_comb begin
        inj_mask = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            inj_mask[i] = inj_err && (inj_byte == IBW'(i));
        end
    end

    assign wr_entry  = '{par: byte_xnor(enq_data) ^ inj_mask, data: enq_data};
    assign head      = mem_q[rd_q[AW-1:0]];
    assign par_err_c = empty ? '0 : (head.par ^ byte_xnor(head.data));

    // Set of the sticky flag takes priority over a same-cycle clear.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        err_d = err_q && !clr_err;
        if (enq_fire) wr_d = wr_q + PW'(1);
        if (deq_fire) rd_d = rd_q + PW'(1);
        if (deq_fire && (|par_err_c)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            err_q <= err_d;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && enq_fire) begin
            mem_q[wr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign enq_ready   = !full;
    assign deq_valid   = !empty;
    assign deq_data    = head.data;
    assign deq_par_err = par_err_c;
    assign err_sticky  = err_q;
    assign count       = wr_q - rd_q;

endmodule
